// File: rtl/line_pair_sched.sv
// -----------------------------------------------------------------------------
// line_pair_sched
//
// Write-side scheduler for the dual-camera line buffer. Two capture channels
// deliver pixel strobes independently. This block turns them into write
// enables and addresses for the two line buffers. It also publishes per-channel
// write heads that the read address generator gates on.
//
// Once both lines are complete and the reader raises rd_finish, both buffers
// are released together, so the two channels stay line-aligned. If one channel
// finishes and the other stalls for TIMEOUT cycles, the lagging line is padded
// (its head is forced to NUM without writing) and the skew flag is raised.
//
// Ports
//   clk                 sole clock
//   rstn                asynchronous, active-low reset
//   de_1, de_2          pixel valid per channel, one pixel per high cycle
//   vs_1, vs_2          frame sync; a rising edge restarts the frame
//   rd_finish           reader has issued its last address for this line
//   we_1, we_2          registered buffer write enables
//   waddr_1, waddr_2    registered buffer write addresses (always < NUM)
//   head_1, head_2      completed writes this line (0..NUM); NUM = line complete
//   line_cnt            lines released since the last frame start (wraps)
//   ovf                 sticky: a pixel was dropped
//   skew                sticky: a timeout pad occurred
// -----------------------------------------------------------------------------
module line_pair_sched #(
    parameter int NUM     = 1280,
    parameter int TIMEOUT = 4096,
    localparam int W      = $clog2(NUM + 1)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         de_1,
    input  logic         de_2,
    input  logic         vs_1,
    input  logic         vs_2,
    input  logic         rd_finish,
    output logic         we_1,
    output logic         we_2,
    output logic [W-1:0] waddr_1,
    output logic [W-1:0] waddr_2,
    output logic [W-1:0] head_1,
    output logic [W-1:0] head_2,
    output logic [15:0]  line_cnt,
    output logic         ovf,
    output logic         skew
);

    // Timer counts 0..TIMEOUT-1, so $clog2(TIMEOUT) bits are enough.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [W-1:0]  NUM_W = W'(NUM);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        REL   = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Per-channel write counts (next address to write) and published heads.
    logic [W-1:0]  cnt_1_q, cnt_1_d, cnt_2_q, cnt_2_d;
    logic [W-1:0]  head_1_q, head_1_d, head_2_q, head_2_d;
    logic          we_1_q, we_1_d, we_2_q, we_2_d;
    logic [W-1:0]  waddr_1_q, waddr_1_d, waddr_2_q, waddr_2_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   line_cnt_q, line_cnt_d;
    logic          ovf_q, ovf_d;
    logic          skew_q, skew_d;

    // Frame-sync edge detection: a sampled copy, its previous value, and a
    // registered detect pulse. The override acts on the cycle after detection.
    logic vs_1_q, vs_1_p_q, vs_2_q, vs_2_p_q;
    logic fs_q;
    logic vs_rise;

    logic full_1, full_2, one_full;
    logic pad;
    logic acc_1, acc_2;

    // -------------------------------------------------------------------------
    // Derived conditions
    // -------------------------------------------------------------------------
    assign full_1   = (head_1_q == NUM_W);
    assign full_2   = (head_2_q == NUM_W);
    assign one_full = full_1 ^ full_2;

    // Pad fires only in FILL with exactly one head complete and the timer
    // expired. A frame-sync override in the same cycle takes precedence.
    assign pad = (state_q == FILL) && !fs_q && one_full && (timer_q == T_MAX);

    // A pixel is accepted only in FILL, outside a frame-sync override or pad
    // cycle, and only while the channel still has room in the line.
    assign acc_1 = (state_q == FILL) && !fs_q && !pad && de_1 && (cnt_1_q != NUM_W);
    assign acc_2 = (state_q == FILL) && !fs_q && !pad && de_2 && (cnt_2_q != NUM_W);

    assign vs_rise = (vs_1_q & ~vs_1_p_q) | (vs_2_q & ~vs_2_p_q);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its inputs, independent of the
    // order in which the always blocks are evaluated.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (fs_q) begin
            state_d = FILL;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (pad || (full_1 && full_2)) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_finish) begin
                        state_d = REL;
                    end
                end
                REL: begin
                    state_d = FILL;
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_1_d    = cnt_1_q;
        cnt_2_d    = cnt_2_q;
        // Heads trail the counts by one cycle, so the reader never addresses
        // a location in the same cycle it is being written.
        head_1_d   = cnt_1_q;
        head_2_d   = cnt_2_q;
        we_1_d     = acc_1;
        we_2_d     = acc_2;
        waddr_1_d  = acc_1 ? cnt_1_q : waddr_1_q;
        waddr_2_d  = acc_2 ? cnt_2_q : waddr_2_q;
        timer_d    = '0;
        line_cnt_d = line_cnt_q;
        ovf_d      = ovf_q;
        skew_d     = skew_q;

        if (fs_q) begin
            // Frame restart: everything line-related goes back to zero. A
            // strobe in this cycle is discarded without being reported.
            cnt_1_d    = '0;
            cnt_2_d    = '0;
            head_1_d   = '0;
            head_2_d   = '0;
            line_cnt_d = '0;
        end else begin
            if (acc_1) begin
                cnt_1_d = cnt_1_q + W'(1);
            end
            if (acc_2) begin
                cnt_2_d = cnt_2_q + W'(1);
            end

            // Any strobe that was not accepted is a dropped pixel.
            if ((de_1 && !acc_1) || (de_2 && !acc_2)) begin
                ovf_d = 1'b1;
            end

            unique case (state_q)
                FILL: begin
                    if (pad) begin
                        // Lagging line is declared complete without writing
                        // the missing addresses.
                        cnt_1_d  = NUM_W;
                        cnt_2_d  = NUM_W;
                        head_1_d = NUM_W;
                        head_2_d = NUM_W;
                        skew_d   = 1'b1;
                    end else if (one_full && !(full_1 ? acc_2 : acc_1)) begin
                        // Leader done, lagging channel idle: keep counting.
                        timer_d = timer_q + TW'(1);
                    end
                end
                DRAIN: begin
                    if (rd_finish) begin
                        // Entering REL: release both buffers for the next line.
                        cnt_1_d    = '0;
                        cnt_2_d    = '0;
                        head_1_d   = '0;
                        head_2_d   = '0;
                        line_cnt_d = line_cnt_q + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_1_q    <= '0;
            cnt_2_q    <= '0;
            head_1_q   <= '0;
            head_2_q   <= '0;
            we_1_q     <= 1'b0;
            we_2_q     <= 1'b0;
            waddr_1_q  <= '0;
            waddr_2_q  <= '0;
            timer_q    <= '0;
            line_cnt_q <= '0;
            ovf_q      <= 1'b0;
            skew_q     <= 1'b0;
            vs_1_q     <= 1'b0;
            vs_1_p_q   <= 1'b0;
            vs_2_q     <= 1'b0;
            vs_2_p_q   <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            cnt_1_q    <= cnt_1_d;
            cnt_2_q    <= cnt_2_d;
            head_1_q   <= head_1_d;
            head_2_q   <= head_2_d;
            we_1_q     <= we_1_d;
            we_2_q     <= we_2_d;
            waddr_1_q  <= waddr_1_d;
            waddr_2_q  <= waddr_2_d;
            timer_q    <= timer_d;
            line_cnt_q <= line_cnt_d;
            ovf_q      <= ovf_d;
            skew_q     <= skew_d;
            vs_1_q     <= vs_1;
            vs_1_p_q   <= vs_1_q;
            vs_2_q     <= vs_2;
            vs_2_p_q   <= vs_2_q;
            fs_q       <= vs_rise;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign we_1     = we_1_q;
    assign we_2     = we_2_q;
    assign waddr_1  = waddr_1_q;
    assign waddr_2  = waddr_2_q;
    assign head_1   = head_1_q;
    assign head_2   = head_2_q;
    assign line_cnt = line_cnt_q;
    assign ovf      = ovf_q;
    assign skew     = skew_q;

endmodule

// File: doc/line_pair_sched.md
# line_pair_sched

Write-side scheduler for the dual-camera line buffer. It accepts pixel strobes from two capture channels and generates the write enables and addresses for both line buffers. It publishes the per-channel write heads `head_1`/`head_2` that the read address generator gates on. Once both lines are complete and the reader reports `finish`, it releases the buffers for the next line, keeping the two channels line-aligned.

## Interface
- `NUM`, 1280: pixels per line; also the head value that means "line complete".
- `TIMEOUT`, 4096: cycles a complete channel waits for a lagging channel before padding.
- Width `W` = $clog2(NUM+1). For `NUM` = 1280, `W` = 11, which matches the reader's head width.

- `clk`  in  1  sole clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `de_1`, `de_2`  in  1  pixel valid, channel 1/2; one pixel per high cycle.
- `vs_1`, `vs_2`  in  1  frame sync, active high; a rising edge restarts the frame.
- `rd_finish`  in  1  level from the read address generator; high once its last address is issued.
- `we_1`, `we_2`  out  1  buffer write enable, channel 1/2.
- `waddr_1`, `waddr_2`  out  W  buffer write address, channel 1/2.
- `head_1`, `head_2`  out  W  count of completed writes this line; 0..NUM.
- `line_cnt`  out  16  lines released since the last frame start; wraps at 65535 -> 0.
- `ovf`  out  1  sticky: a pixel was dropped.
- `skew`  out  1  sticky: a timeout pad occurred.

## Operation
- **Reset:** all outputs are 0 and the state is FILL. `ovf`/`skew` clear only on `rstn`.
- **States:** FILL, DRAIN, REL.
- **FILL:**
  - For each channel n independently: if `de_n`=1 and the channel's write count < NUM, the pixel is accepted.
  - An accepted pixel is written at address = count, and the count increments by 1.
  - If the count is already NUM, the pixel is dropped and `ovf` is set.
- **FILL -> DRAIN:** when both heads equal NUM.
- **Timeout (FILL only):**
  - The timer runs while exactly one head equals NUM.
  - It reloads to 0 on any accepted pixel of the lagging channel, and when neither or both heads are at NUM.
  - When it reaches `TIMEOUT`-1: the lagging head is forced to NUM with no writes for the padded addresses, `skew` is set, and the state goes to DRAIN.
- **DRAIN:**
  - Heads hold at NUM, and no writes occur.
  - Any `de_n` is dropped and sets `ovf`.
  - Exits to REL on the first cycle `rd_finish`=1.
- **REL:**
  - Lasts exactly one cycle.
  - Both heads and write counts are 0, and `line_cnt` increments.
  - `de_n` in this cycle is dropped and sets `ovf`.
  - Next state is FILL.
  - Heads leaving NUM make the reader clear `rd_finish` and restart at address 0.
  - A stale `rd_finish` cannot be seen in the next DRAIN, because reaching DRAIN takes at least NUM cycles.
- **Frame sync:**
  - The rising edge of `vs_1` or `vs_2` is detected from a registered copy of each signal.
  - The detected edge overrides every state: heads/counts to 0, `line_cnt` to 0, timer to 0, state to FILL.
  - `de_n` in the detect cycle is dropped and does not set `ovf`.
- **Priority:** reset > frame-sync edge > timeout > normal transitions.
- **Mid-line reset:** `rstn` low at any point returns everything to the reset values immediately.
- **Arithmetic:** counts saturate at NUM and never exceed it. `waddr` is always < NUM.

## Timing
- **Pixel acceptance:** edge k samples `de_n`=1 in FILL. After edge k: `we_n`=1 and `waddr_n`=count. After edge k+1: `head_n`=count+1.
  - The head therefore lags the write by one cycle, so the reader never addresses a location in the same cycle it is written.
- **`we_n` deassertion:** `we_n` is registered and is low in any cycle after a non-accepted sample.
- **Enter DRAIN:** one edge after the cycle in which both heads read NUM, or on the timeout edge.
- **Enter REL:** one edge after `rd_finish` is sampled high in DRAIN.
- **Leave REL:** REL is one cycle. The first new-line pixel can be sampled in the cycle after REL; its `we` appears one cycle later.
- **Frame-sync latency:** the `vs` rising edge is sampled at edge k and detected at edge k+1. Heads read 0 after edge k+2.
- **Timeout:** padding occurs `TIMEOUT` cycles after the leading head reaches NUM if the lagging channel is idle throughout.

## Test plan
- **Aligned line:** NUM=8, both `de` high 8 cycles together.
  - `waddr` 0..7 with `we` each cycle; heads reach 8 one cycle after the last `we`; DRAIN follows.
  - `rd_finish`=1 -> REL: heads are 0 for one cycle and `line_cnt` becomes 1.
- **Skewed channels:** `de_2` lags `de_1` by 3 cycles, no idle gap.
  - `head_1` holds 8 while `head_2` finishes; no `skew`; DRAIN begins after `head_2`=8.
- **Timeout:** NUM=8, TIMEOUT=16; channel 1 completes while channel 2 stops at 5.
  - After 16 cycles `head_2` jumps 5->8 with no `we_2`, `skew`=1, DRAIN.
- **Overrun:** `de_1` held 10 cycles in FILL.
  - Exactly 8 `we_1` pulses, `ovf`=1, `head_1` saturates at 8. Pixels in DRAIN or REL also set `ovf`.
- **Frame sync mid-line:** `vs_1` rises while heads are at 4.
  - Heads read 0 two edges later, `line_cnt`=0, state FILL; the next `de` writes `waddr` 0; `ovf` is not set by the dropped detect-cycle pixel.
- **Async reset:** `rstn` is pulsed low during DRAIN.
  - All outputs are 0 immediately, without waiting for a clock edge; the next line starts at `waddr` 0.
